// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl: simpleuart sequencer decoding colour commands, echoing them and sharing TX with an external requester
// Ports: hw_clk/resetn clock and synchronous active-low reset; reg_dat_* simpleuart data register;
//        ext_req/ext_data/ext_gnt external transmit requester; rgb_* PWM enables;
//        cmd_err unrecognised-byte pulse; rx_count consumed-byte counter
module uart_link_ctrl #(
    parameter bit         BANNER_EN   = 1'b1,
    parameter logic [7:0] BANNER_CHAR = 8'h50,
    parameter logic [2:0] RESET_RGB   = 3'b010
) (
    input  logic        hw_clk,
    input  logic        resetn,
    output logic        reg_dat_we,
    output logic        reg_dat_re,
    output logic [31:0] reg_dat_di,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    input  logic        ext_req,
    input  logic [7:0]  ext_data,
    output logic        ext_gnt,
    output logic        rgb_red,
    output logic        rgb_green,
    output logic        rgb_blue,
    output logic        cmd_err,
    output logic [7:0]  rx_count
);
    typedef enum logic [1:0] {BANNER, IDLE, RXRD, TXWAIT} state_t;
    typedef enum logic [1:0] {SRC_BAN, SRC_ECHO, SRC_EXT} src_t;
    state_t     st;
    src_t       src;
    logic       echo_pend, rr_ext, rx_ok, ext_ok, take_echo, is_digit;
    logic [7:0] echo_byte, rx_b;
    always_comb begin
        rx_b      = reg_dat_do[7:0];
        rx_ok     = reg_dat_do != 32'hFFFF_FFFF && !echo_pend;
        is_digit  = rx_b[7:3] == 5'b00110;
        // the requester still sees its request high during the grant pulse
        ext_ok    = ext_req && !ext_gnt;
        take_echo = echo_pend && (!ext_ok || rr_ext);
    end
    always_ff @(posedge hw_clk) begin
        if (!resetn) begin
            st                              <= BANNER_EN ? BANNER : IDLE;
            src                             <= SRC_BAN;
            reg_dat_we                      <= 1'b0;
            reg_dat_re                      <= 1'b0;
            reg_dat_di                      <= 32'd0;
            ext_gnt                         <= 1'b0;
            cmd_err                         <= 1'b0;
            rx_count                        <= 8'd0;
            {rgb_red, rgb_green, rgb_blue}  <= RESET_RGB;
            echo_pend                       <= 1'b0;
            echo_byte                       <= 8'd0;
            rr_ext                          <= 1'b1;
        end else begin
            reg_dat_re <= 1'b0;
            ext_gnt    <= 1'b0;
            cmd_err    <= 1'b0;
            case (st)
                BANNER: begin
                    reg_dat_we <= 1'b1;
                    reg_dat_di <= {24'd0, BANNER_CHAR};
                    src        <= SRC_BAN;
                    st         <= TXWAIT;
                end
                IDLE: begin
                    if (rx_ok) begin
                        reg_dat_re <= 1'b1;
                        rx_count   <= rx_count + 8'd1;
                        echo_pend  <= 1'b1;
                        echo_byte  <= is_digit ? rx_b : 8'h3F;
                        cmd_err    <= !is_digit;
                        if (is_digit) {rgb_red, rgb_green, rgb_blue} <= rx_b[2:0];
                        st         <= RXRD;
                    end else if (echo_pend || ext_ok) begin
                        reg_dat_we <= 1'b1;
                        reg_dat_di <= {24'd0, take_echo ? echo_byte : ext_data};
                        src        <= take_echo ? SRC_ECHO : SRC_EXT;
                        st         <= TXWAIT;
                    end
                end
                RXRD: st <= IDLE;
                TXWAIT: begin
                    if (!reg_dat_wait) begin
                        reg_dat_we <= 1'b0;
                        st         <= IDLE;
                        if (src == SRC_ECHO) begin
                            echo_pend <= 1'b0;
                            rr_ext    <= 1'b0;
                        end
                        if (src == SRC_EXT) begin
                            ext_gnt <= 1'b1;
                            rr_ext  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb_uart_link_ctrl: self-checking bench for uart_link_ctrl (vector table, directed corner cases, randomized traffic vs model)
module tb_uart_link_ctrl;
    logic        hw_clk = 1'b0;
    logic        resetn, reg_dat_we, reg_dat_re, reg_dat_wait, ext_req, ext_gnt;
    logic        rgb_red, rgb_green, rgb_blue, cmd_err;
    logic [31:0] reg_dat_di, reg_dat_do;
    logic [7:0]  ext_data, rx_count;
    logic [2:0]  rgb;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [7:0] rx;
        logic [2:0] rgb;
        logic       err;
        logic [7:0] echo;
    } vec_t;
    vec_t vecs [7];

    logic [7:0]  rxq [$];
    logic [7:0]  eq [$];
    logic [7:0]  b_rx;
    logic [2:0]  mrgb;
    logic        dig, exp_acc, acc_ext, prev_we, prev_re;
    logic [31:0] prev_di, want;
    int          n, cyc, ext_issued, ext_done;

    assign rgb = {rgb_red, rgb_green, rgb_blue};
    always #5 hw_clk = ~hw_clk;

    uart_link_ctrl dut (
        .hw_clk(hw_clk), .resetn(resetn),
        .reg_dat_we(reg_dat_we), .reg_dat_re(reg_dat_re), .reg_dat_di(reg_dat_di),
        .reg_dat_do(reg_dat_do), .reg_dat_wait(reg_dat_wait),
        .ext_req(ext_req), .ext_data(ext_data), .ext_gnt(ext_gnt),
        .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
        .cmd_err(cmd_err), .rx_count(rx_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge hw_clk);
    endtask

    task automatic wait_sig(input string name, input bit use_re);
        int k = 0;
        while ((use_re ? reg_dat_re : reg_dat_we) !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk(name, use_re ? reg_dat_re : reg_dat_we, 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        reg_dat_do = {24'd0, b};
        wait_sig("re_pulse", 1);
        reg_dat_do = 32'hFFFF_FFFF;
    endtask

    task automatic tx_expect(input string name, input logic [7:0] b, input logic is_ext);
        wait_sig({name, "_we"}, 0);
        chk({name, "_di"}, reg_dat_di, {24'd0, b});
        reg_dat_wait = 1'b0;
        tick();
        chk({name, "_we_fall"}, reg_dat_we, 0);
        chk({name, "_gnt"}, ext_gnt, is_ext);
        if (is_ext) ext_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h35, 3'b101, 1'b0, 8'h35};
        vecs[1] = '{8'h41, 3'b101, 1'b1, 8'h3F};
        vecs[2] = '{8'h30, 3'b000, 1'b0, 8'h30};
        vecs[3] = '{8'h37, 3'b111, 1'b0, 8'h37};
        vecs[4] = '{8'h38, 3'b111, 1'b1, 8'h3F};
        vecs[5] = '{8'h2F, 3'b111, 1'b1, 8'h3F};
        vecs[6] = '{8'h32, 3'b010, 1'b0, 8'h32};
        resetn = 1'b0; reg_dat_do = 32'hFFFF_FFFF; reg_dat_wait = 1'b0; ext_req = 1'b0; ext_data = 8'h00;
        repeat (3) tick();
        chk("rst_we", reg_dat_we, 0);
        chk("rst_re", reg_dat_re, 0);
        chk("rst_di", reg_dat_di, 0);
        chk("rst_gnt", ext_gnt, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_rgb", rgb, 3'b010);
        chk("rst_cnt", rx_count, 0);
        resetn = 1'b1;
        tick();
        chk("banner_we", reg_dat_we, 1);
        chk("banner_di", reg_dat_di, 32'h50);
        chk("banner_rgb", rgb, 3'b010);
        tick();
        chk("banner_we_fall", reg_dat_we, 0);
        chk("banner_rgb_after", rgb, 3'b010);
        for (int i = 0; i < 7; i++) begin
            send_rx(vecs[i].rx);
            chk("vec_rgb", rgb, vecs[i].rgb);
            chk("vec_err", cmd_err, vecs[i].err);
            chk("vec_cnt", rx_count, i + 1);
            tick();
            chk("vec_re_single", reg_dat_re, 0);
            chk("vec_err_single", cmd_err, 0);
            chk("vec_we_early", reg_dat_we, 0);
            tick();
            chk("vec_echo_latency", reg_dat_we, 1);
            tx_expect("vec_echo", vecs[i].echo, 0);
        end
        ext_data = 8'h99; ext_req = 1'b1;
        tx_expect("ext_only", 8'h99, 1);
        tick();
        chk("ext_gnt_single", ext_gnt, 0);
        send_rx(8'h33);
        ext_data = 8'h21; ext_req = 1'b1;
        tx_expect("rr_echo_first", 8'h33, 0);
        tx_expect("rr_ext_second", 8'h21, 1);
        chk("rr_rgb", rgb, 3'b011);
        tick();
        chk("rr_gnt_single", ext_gnt, 0);
        send_rx(8'h31);
        tx_expect("echo_only", 8'h31, 0);
        send_rx(8'h34);
        ext_data = 8'h22; ext_req = 1'b1;
        tx_expect("rr_ext_first", 8'h22, 1);
        tx_expect("rr_echo_second", 8'h34, 0);
        reg_dat_wait = 1'b1; ext_data = 8'h5A; ext_req = 1'b1;
        wait_sig("hold_we", 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_we_stable", reg_dat_we, 1);
            chk("hold_di_stable", reg_dat_di, 32'h5A);
            chk("hold_gnt_early", ext_gnt, 0);
        end
        reg_dat_wait = 1'b0;
        tick();
        chk("hold_accept_we", reg_dat_we, 0);
        chk("hold_accept_gnt", ext_gnt, 1);
        ext_req = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_no_dup_we", reg_dat_we, 0);
            chk("hold_no_dup_gnt", ext_gnt, 0);
        end
        reg_dat_wait = 1'b1;
        send_rx(8'h36);
        ext_data = 8'h66; ext_req = 1'b1;
        wait_sig("rst_mid_we", 0);
        chk("rst_mid_di", reg_dat_di, 32'h36);
        resetn = 1'b0;
        tick();
        chk("rst_mid_we_drop", reg_dat_we, 0);
        chk("rst_mid_gnt", ext_gnt, 0);
        chk("rst_mid_rgb", rgb, 3'b010);
        chk("rst_mid_cnt", rx_count, 0);
        repeat (2) begin
            tick();
            chk("rst_mid_gnt_hold", ext_gnt, 0);
        end
        ext_req = 1'b0; reg_dat_wait = 1'b0; resetn = 1'b1;
        tx_expect("post_rst_banner", 8'h50, 0);

        resetn = 1'b0; reg_dat_do = 32'hFFFF_FFFF; reg_dat_wait = 1'b0; ext_req = 1'b0;
        tick();
        tick();
        eq.push_back(8'h50);
        mrgb = 3'b010; n = 0; exp_acc = 1'b0; acc_ext = 1'b0; prev_we = 1'b0; prev_re = 1'b0;
        ext_issued = 0; ext_done = 0; cyc = 0;
        resetn = 1'b1;
        while (cyc < 30000 && (cyc < 8000 || rxq.size() != 0 || eq.size() != 0 || ext_req || reg_dat_we || exp_acc)) begin
            tick();
            cyc++;
            if (exp_acc) begin
                chk("rnd_we_fall", reg_dat_we, 0);
                chk("rnd_gnt", ext_gnt, acc_ext);
                if (acc_ext) begin
                    ext_req = 1'b0;
                    ext_done++;
                end
            end else begin
                chk("rnd_gnt_spurious", ext_gnt, 0);
                if (prev_we) begin
                    chk("rnd_we_hold", reg_dat_we, 1);
                    chk("rnd_di_hold", reg_dat_di, prev_di);
                end
            end
            if (reg_dat_re) begin
                chk("rnd_re_single", prev_re, 0);
                chk("rnd_re_valid", rxq.size() != 0, 1);
                if (rxq.size() != 0) begin
                    b_rx = rxq.pop_front();
                    n++;
                    dig = b_rx >= 8'h30 && b_rx <= 8'h37;
                    if (dig) mrgb = b_rx[2:0];
                    eq.push_back(dig ? b_rx : 8'h3F);
                    chk("rnd_err", cmd_err, !dig);
                    chk("rnd_cnt", rx_count, n % 256);
                    if (n == 256) chk("rnd_cnt_wrap", rx_count, 0);
                end
            end else begin
                chk("rnd_err_idle", cmd_err, 0);
            end
            chk("rnd_rgb", rgb, mrgb);
            prev_re = reg_dat_re; prev_we = reg_dat_we; prev_di = reg_dat_di;
            reg_dat_wait = $urandom_range(0, 2) == 0;
            exp_acc = reg_dat_we && !reg_dat_wait;
            acc_ext = 1'b0;
            if (exp_acc) begin
                acc_ext = ext_req && reg_dat_di[7];
                want = acc_ext ? {24'd0, ext_data} : (eq.size() != 0 ? {24'd0, eq[0]} : 32'hDEAD_BEEF);
                chk("rnd_tx_byte", reg_dat_di, want);
                if (!acc_ext && eq.size() != 0) void'(eq.pop_front());
            end
            if (cyc < 8000 && !ext_req && !ext_gnt && $urandom_range(0, 9) == 0) begin
                ext_data = 8'h80 | 8'($urandom_range(0, 127));
                ext_req = 1'b1;
                ext_issued++;
            end
            if (cyc < 8000 && rxq.size() < 3 && $urandom_range(0, 3) == 0)
                rxq.push_back(8'($urandom_range(8'h2E, 8'h42)));
            reg_dat_do = rxq.size() != 0 ? {24'd0, rxq[0]} : 32'hFFFF_FFFF;
        end
        chk("rnd_drained_echo", eq.size(), 0);
        chk("rnd_drained_rx", rxq.size(), 0);
        chk("rnd_ext_served", ext_done, ext_issued);
        chk("rnd_enough_rx", n > 256, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_link_ctrl.md
Name: uart_link_ctrl

Overview:
Sequencing controller for the simpleuart register interface (reg_dat_we/re/di/do/wait) on the hw_clk domain. It consumes received bytes, decodes single-character colour commands into RGB PWM enables, and echoes each command. It also shares the UART transmit path between the internal echo source and one external transmit requester using round-robin arbitration. It sits between simpleuart and the SB_RGBA_DRV in the top level and replaces ad-hoc top-level state logic.

Parameters:
BANNER_EN, 1, send BANNER_CHAR once after reset release (0 = skip)
BANNER_CHAR, 8'h50 ("P"), startup character
RESET_RGB, 3'b010, {red,green,blue} value while in reset and until the first command

Ports:
hw_clk  in  1  system clock, 12 MHz
resetn  in  1  synchronous, active-low reset
reg_dat_we  out  1  UART write strobe, held until accepted
reg_dat_re  out  1  UART read strobe, single-cycle pulse
reg_dat_di  out  32  UART write data; bits [31:8] are always 0
reg_dat_do  in  32  UART read data; 32'hFFFF_FFFF means no byte pending
reg_dat_wait  in  1  UART busy; a write is accepted in a cycle where we=1 and wait=0
ext_req  in  1  external transmit request, level, held until granted
ext_data  in  8  external byte, stable while ext_req=1
ext_gnt  out  1  one-cycle pulse in the cycle the external byte is accepted
rgb_red  out  1  red PWM enable
rgb_green  out  1  green PWM enable
rgb_blue  out  1  blue PWM enable
cmd_err  out  1  one-cycle pulse when an unrecognised byte is received
rx_count  out  8  count of bytes consumed; wraps 255->0

Behaviour:
- Reset (resetn=0 at hw_clk edge):
  - we=0, re=0, di=0, ext_gnt=0, cmd_err=0, rx_count=0.
  - {rgb_red,rgb_green,rgb_blue}=RESET_RGB; echo_pend=0; rr_last=ext (echo wins the first tie); state=BANNER if BANNER_EN, else IDLE.
  - Reset asserted mid-transfer drops we immediately and abandons pending echo/ext bytes. No ext_gnt is issued.
- States:
  - BANNER: drive di=BANNER_CHAR, we=1, go TXWAIT (banner source).
  - IDLE: RX check first, then TX arbitration, in the same cycle.
  - RXRD: re=1 for exactly this one cycle; return to IDLE.
  - TXWAIT: hold we=1 and di; if wait=0 this cycle, the write is accepted. Next cycle: we=0, clear the granted source, update rr_last, back to IDLE.
- RX (IDLE, reg_dat_do != 32'hFFFF_FFFF, echo_pend=0):
  - Capture byte b = reg_dat_do[7:0], rx_count++, go RXRD.
  - b in "0".."7": {r,g,b} <= b[2:0] from the next cycle; echo byte = b.
  - Else: colour unchanged; cmd_err pulses the next cycle; echo byte = "?" (8'h3F).
  - echo_pend <= 1.
  - If echo_pend=1, RX is not consumed and the byte stays in simpleuart (backpressure; a later overwrite by simpleuart is accepted loss).
  - reg_dat_do is not sampled during RXRD or TXWAIT.
- TX arbitration (IDLE, no RX taken this cycle):
  - Requesters are echo_pend and ext_req.
  - Only one pending: grant it.
  - Both pending: grant the one not equal to rr_last.
  - On grant: di={24'b0,byte}, we=1, go TXWAIT.
  - ext_gnt pulses in the cycle after acceptance, together with we falling.
  - ext_data is latched at grant.
- Latency:
  - RX byte visible -> re pulse: 1 cycle.
  - Colour update: 1 cycle after capture.
  - Echo we rises 2 cycles after capture (RXRD, IDLE) when TX is idle.
- At most one outstanding UART write; we never deasserts before acceptance.

Test Plan:
- Reset release, BANNER_EN=1, wait=0 -> we=1 with di=32'h50 on the cycle after release, accepted, we=0 next cycle; rgb=010 throughout.
- reg_dat_do=32'h35 ("5") -> re pulses once, rgb becomes 101, echo di=32'h35 written, rx_count=1.
- reg_dat_do=32'h41 ("A") -> cmd_err single pulse, rgb unchanged, echo di=32'h3F.
- ext_req=1 with ext_data=8'h21 while echo pending, rr_last=ext -> echo granted first, then ext. ext_gnt pulses once after the second acceptance, and di=32'h21.
- wait=1 held for 20 cycles during a write -> we and di stay stable all 20 cycles, acceptance on the first wait=0 cycle, no duplicate write.
- resetn=0 asserted during TXWAIT with ext pending -> we=0 next edge, no ext_gnt, rgb=RESET_RGB, rx_count=0; 256 consumed bytes -> rx_count wraps to 0.
